// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- 8N1 UART transmit controller driving an external
// LSB-first parallel-in/serial-out shift register.
//
// A byte is accepted over a valid/ready handshake and latched into
// piso_data. The controller then loads the shift register, times each bit
// with an internal baud counter, and issues one shift per data bit. It
// drives tx with a start bit, eight data bits (LSB first) and a stop bit.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   tx_data[7:0] in   byte to send, sampled on the acceptance edge only
//   tx_valid     in   upstream has a byte
//   tx_ready     out  controller can accept (IDLE and not in reset)
//   piso_data    out  registered accepted byte -> shift register parallel in
//   piso_enb     out  shift register enable
//   piso_l_s     out  shift register mode, 1 = load / 0 = shift
//   piso_serial  in   shift register serial output (current LSB)
//   tx           out  UART line, idle high
//   tx_busy      out  frame in progress
//   tx_done      out  one-cycle pulse in the first IDLE cycle after a stop bit
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] piso_data,
  output logic       piso_enb,
  output logic       piso_l_s,
  input  logic       piso_serial,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             tick;
  logic             accept;

  assign tick     = (baud_cnt == CNT_LAST);
  assign tx_ready = (state == IDLE) & ~rst;
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid & tx_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, line level and shift-register commands. tx depends only on
  // state and piso_serial, both registered, so upstream inputs never reach
  // the line combinationally.
  always_comb begin
    state_n  = state;
    tx       = 1'b1;
    piso_enb = 1'b0;
    piso_l_s = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_n = START;
      end
      START: begin
        tx = 1'b0;
        // Load in the first START cycle so bit 0 is already on piso_serial
        // long before DATA begins.
        if (baud_cnt == '0) begin
          piso_enb = 1'b1;
          piso_l_s = 1'b1;
        end
        if (tick) state_n = DATA;
      end
      DATA: begin
        tx = piso_serial;
        // Shift at the end of each bit to expose the next one; the shift
        // after bit 7 is never observed.
        if (tick) begin
          piso_enb = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: baud counter, bit index, byte latch, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      piso_data <= 8'h00;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= (state == STOP) & tick;
      if (state == IDLE) begin
        baud_cnt <= '0;
        if (accept) begin
          piso_data <= tx_data;
          bit_idx   <= '0;
        end
      end else begin
        baud_cnt <= tick ? '0 : baud_cnt + CNT_W'(1);
        if (state == DATA && tick) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: one instance with 4 clocks per bit, one with the
// minimum of 2, each feeding a behavioural LSB-first shift register.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;
  assign rst_n = ~rst;

  // instance A: CLKS_PER_BIT = 4
  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_enb, a_ls, a_ser, a_tx, a_busy, a_done;
  logic [7:0] a_pdata, sr_a;

  uart_tx_ctrl #(.CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid),
    .tx_ready(a_ready), .piso_data(a_pdata), .piso_enb(a_enb),
    .piso_l_s(a_ls), .piso_serial(a_ser), .tx(a_tx), .tx_busy(a_busy),
    .tx_done(a_done)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     sr_a <= 8'h00;
    else if (a_enb) sr_a <= a_ls ? a_pdata : {1'b0, sr_a[7:1]};
  assign a_ser = sr_a[0];

  // instance B: CLKS_PER_BIT = 2
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_enb, b_ls, b_ser, b_tx, b_busy, b_done;
  logic [7:0] b_pdata, sr_b;

  uart_tx_ctrl #(.CLKS_PER_BIT(2)) u_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid),
    .tx_ready(b_ready), .piso_data(b_pdata), .piso_enb(b_enb),
    .piso_l_s(b_ls), .piso_serial(b_ser), .tx(b_tx), .tx_busy(b_busy),
    .tx_done(b_done)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     sr_b <= 8'h00;
    else if (b_enb) sr_b <= b_ls ? b_pdata : {1'b0, sr_b[7:1]};
  assign b_ser = sr_b[0];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line levels for a frame, one bit per clock: sample j = slot j/cpb of
  // {stop, data[7:0], start}.
  function automatic logic [63:0] expand(input logic [7:0] b, input int cpb);
    logic [9:0]  f;
    logic [63:0] v;
    f = {1'b1, b, 1'b0};
    v = '0;
    for (int i = 0; i < 10 * cpb; i++) v[i] = f[i / cpb];
    return v;
  endfunction

  // Send one byte on instance A. Called one step after an edge with A idle.
  // hold keeps tx_valid high for a back-to-back follow-up; noise toggles
  // tx_valid and corrupts tx_data while the frame is in flight.
  task automatic send_a(input logic [7:0] b, input bit hold, input bit noise, input string tag);
    logic [63:0] v;
    int loads, shifts, dones, rdy;
    v = '0; loads = 0; shifts = 0; dones = 0; rdy = 0;
    a_data  = b;
    a_valid = 1'b1;
    step();
    if (!hold) a_valid = 1'b0;
    for (int j = 0; j < 40; j++) begin
      v[j] = a_tx;
      if (a_enb && a_ls)  loads++;
      if (a_enb && !a_ls) shifts++;
      if (a_done)  dones++;
      if (a_ready) rdy++;
      if (noise && j >= 2 && j < 36) begin
        a_valid = (j % 2 == 0);
        a_data  = 8'hFF;
      end
      if (noise && j == 36) a_valid = 1'b0;
      step();
    end
    chk($sformatf("%s_line", tag), v, expand(b, 4));
    chk($sformatf("%s_loads", tag), 64'(loads), 64'd1);
    chk($sformatf("%s_shifts", tag), 64'(shifts), 64'd8);
    chk($sformatf("%s_early_done", tag), 64'(dones), 64'd0);
    chk($sformatf("%s_ready_in_frame", tag), 64'(rdy), 64'd0);
    chk($sformatf("%s_done", tag), 64'(a_done), 64'd1);
    chk($sformatf("%s_ready_after", tag), 64'(a_ready), 64'd1);
    chk($sformatf("%s_idle_tx", tag), 64'(a_tx), 64'd1);
    if (!hold) begin
      step();
      chk($sformatf("%s_done_once", tag), 64'(a_done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    int dn, loads, shifts;

    // reset held for 3 cycles
    rst = 1'b1;
    repeat (3) step();
    chk("rst_tx", 64'(a_tx), 64'd1);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_enb", 64'(a_enb), 64'd0);
    chk("rst_ls", 64'(a_ls), 64'd0);
    chk("rst_ready", 64'(a_ready), 64'd0);
    chk("rst_pdata", 64'(a_pdata), 64'h00);
    chk("rst_b_tx", 64'(b_tx), 64'd1);
    rst = 1'b0;
    step();
    chk("rel_ready", 64'(a_ready), 64'd1);
    chk("rel_tx", 64'(a_tx), 64'd1);

    // single frame
    send_a(8'hA5, 1'b0, 1'b0, "a5");
    step();

    // back-to-back with tx_valid held
    send_a(8'h00, 1'b1, 1'b0, "b2b_00");
    send_a(8'hFF, 1'b0, 1'b0, "b2b_ff");
    step();

    // handshake noise during a frame
    send_a(8'h3C, 1'b0, 1'b1, "3c");
    chk("3c_pdata", 64'(a_pdata), 64'h3C);
    step();

    // reset during data bit 3 of 8'h55 (slot 4 -> samples 16..19)
    a_data  = 8'h55;
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    repeat (17) step();
    chk("mid_busy", 64'(a_busy), 64'd1);
    chk("mid_bit3", 64'(a_tx), 64'd0);
    rst = 1'b1;
    step();
    chk("mrst_tx", 64'(a_tx), 64'd1);
    chk("mrst_busy", 64'(a_busy), 64'd0);
    chk("mrst_ready", 64'(a_ready), 64'd0);
    rst = 1'b0;
    dn = 0;
    repeat (50) begin
      step();
      if (a_done) dn++;
    end
    chk("mrst_no_done", 64'(dn), 64'd0);
    chk("mrst_ready_after", 64'(a_ready), 64'd1);
    send_a(8'h81, 1'b0, 1'b0, "81");

    // minimum bit width instance
    b_data  = 8'h01;
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    v = '0; loads = 0; shifts = 0; dn = 0;
    for (int j = 0; j < 20; j++) begin
      v[j] = b_tx;
      if (b_enb && b_ls)  loads++;
      if (b_enb && !b_ls) shifts++;
      if (b_done) dn++;
      step();
    end
    chk("min_line", v, expand(8'h01, 2));
    chk("min_loads", 64'(loads), 64'd1);
    chk("min_shifts", 64'(shifts), 64'd8);
    chk("min_early_done", 64'(dn), 64'd0);
    chk("min_done", 64'(b_done), 64'd1);
    chk("min_ready", 64'(b_ready), 64'd1);
    step();
    chk("min_done_once", 64'(b_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that sits directly upstream of the LSB-first parallel-in/serial-out shift register in the UART TX path. It accepts a byte over a valid/ready handshake, loads it into the shift register, times each bit with an internal baud counter, commands one shift per data bit, and drives the serial `tx` line with a start bit, eight data bits (LSB first) and a stop bit (8N1).

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535; counter width is `$clog2(CLKS_PER_BIT)`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to transmit; sampled only on the acceptance edge.
- `tx_valid`  in  1  upstream has a byte.
- `tx_ready`  out  1  controller can accept; `(state==IDLE) & ~rst`.
- `piso_data`  out  8  registered copy of the accepted byte; drives the shift-register parallel input.
- `piso_enb`  out  1  shift-register enable.
- `piso_l_s`  out  1  shift-register mode: 1 = load, 0 = shift.
- `piso_serial`  in  1  shift-register serial output (current LSB).
- `tx`  out  1  UART serial line; idle high.
- `tx_busy`  out  1  high whenever state != IDLE.
- `tx_done`  out  1  one-cycle pulse after a frame's stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP. Registers: `state`, `baud_cnt`, `bit_idx` (3 bits), `piso_data`, `tx_done`.
- Bit tick: `tick = (baud_cnt == CLKS_PER_BIT-1)`. Outside IDLE, `baud_cnt` increments every cycle and wraps to 0 on tick; in IDLE it is held at 0.
- IDLE: `tx`=1. On `tx_valid & tx_ready` at an edge: `piso_data <= tx_data`, `baud_cnt <= 0`, `bit_idx <= 0`, go to START.
- START: `tx`=0. Combinational `piso_enb`=1, `piso_l_s`=1 only in the first START cycle (`baud_cnt==0`), so the shift register loads `piso_data` on that edge. On tick -> DATA.
- DATA: `tx = piso_serial`. On every tick: `piso_enb`=1, `piso_l_s`=0 (one shift, exposing the next bit), `bit_idx` increments; on tick with `bit_idx==7` -> STOP. Shift after bit 7 is harmless.
- STOP: `tx`=1. On tick -> IDLE and `tx_done <= 1` for exactly one cycle.
- `piso_enb`=0 in every cycle not listed above; `piso_l_s`=0 except during the load cycle.
- `tx_valid` is ignored when not in IDLE; changes on `tx_data` after acceptance do not affect the frame in flight.
- `tx` is a mux of registered signals only (state, `piso_serial`); no combinational path from `tx_valid`/`tx_data` to `tx`.

## Timing
- Reset (edge with `rst`=1): state IDLE, `baud_cnt`=0, `bit_idx`=0, `piso_data`=8'h00, `tx_done`=0; hence `tx`=1, `tx_busy`=0, `piso_enb`=0, `piso_l_s`=0; `tx_ready`=0 while `rst` high, 1 on the first cycle after release.
- Reset mid-frame (any state): IDLE on the same edge, `tx`=1 next cycle, no `tx_done` pulse, partial frame abandoned.
- Latency: start bit appears on `tx` the cycle after the acceptance edge.
- Frame length: exactly `10*CLKS_PER_BIT` cycles from first START cycle to first IDLE cycle; each bit lasts exactly `CLKS_PER_BIT` cycles.
- `tx_done` is high in the first IDLE cycle after STOP, coincident with `tx_ready`=1.
- Back-to-back: with `tx_valid` held, the next byte is accepted in that first IDLE cycle; minimum line gap is one extra high cycle (stop level lasts `CLKS_PER_BIT+1`).
- Load-to-use: shift register loads at end of START cycle 0; bit 0 is valid on `piso_serial` from START cycle 1, well before DATA (requires `CLKS_PER_BIT>=2`).

## Test plan
Bench instantiates the block with `CLKS_PER_BIT`=4 and a behavioural LSB-first shift register (its active-low reset tied to `~rst`).
- Reset held 3 cycles, released -> `tx`=1, `tx_busy`=0, `tx_done`=0, `piso_enb`=0, `tx_ready`=0 during reset and 1 after.
- Send 8'hA5 -> `tx` = 0, 1,0,1,0,0,1,0,1, 1, each exactly 4 cycles (40 total); `piso_enb`&`piso_l_s` high for 1 cycle; 8 shift pulses; `tx_done` single pulse in cycle 41.
- `tx_valid` held with 8'h00 then 8'hFF -> two frames, 10 zeros-ish pattern then all-ones data, 5-cycle high between frames, two `tx_done` pulses.
- During 8'h3C frame, pulse `tx_valid` and change `tx_data` to 8'hFF -> ignored; line still shows 8'h3C LSB first; `tx_ready`=0 throughout.
- Assert `rst` for 1 cycle during data bit 3 of 8'h55 -> `tx`=1 next cycle, IDLE, no `tx_done`; a following 8'h81 transmits correctly.
- Rebuild with `CLKS_PER_BIT`=2, send 8'h01 -> 20-cycle frame, bit 0 high for 2 cycles, correct data despite minimum bit width.
